// File: rtl/bytecode_fetch_ctrl.sv
// Bytecode fetch controller: owns the bytecode PC, issues IRAM reads and buffers bytes for the decoder.
// Optional build macro FETCH_STATS_EN adds the o_stat_bytes / o_stat_starve counters.
module bytecode_fetch_ctrl #(
  parameter int ADR_W = 16,
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [ADR_W-1:0] i_start_adr,
  input  logic             i_redirect,
  input  logic [ADR_W-1:0] i_redirect_adr,
  input  logic             i_hold,
  output logic             o_iram_rd,
  output logic [ADR_W-1:0] o_iram_adr,
  input  logic [7:0]       i_iram_q,
  output logic [7:0]       o_byte_data,
  output logic             o_byte_valid,
  input  logic             i_byte_pop,
  output logic             o_waiting,
  output logic [ADR_W-1:0] o_head_pc,
  output logic [LVL_W-1:0] o_level,
`ifdef FETCH_STATS_EN
  output logic [31:0]      o_stat_bytes,
  output logic [31:0]      o_stat_starve,
`endif
  output logic [1:0]       o_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  // Debug state encoding: IDLE is 0.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [ADR_W-1:0] r_fetch_ptr, r_head_pc;
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_inflight;

  logic             w_redir, w_issue, w_push, w_pop, w_valid, w_waiting;
  logic [ADR_W-1:0] w_target;

  // Handshake: o_byte_valid/o_byte_data describe the head; a byte is consumed on a cycle where
  // i_byte_pop && o_byte_valid (and no redirect/start); i_byte_pop without o_byte_valid is ignored.
  always_comb begin
    w_valid     = (r_level != '0);
    w_waiting   = (r_state == S_IDLE) || !w_valid;
    w_redir     = i_start || (i_redirect && (r_state != S_IDLE));
    w_target    = i_start ? i_start_adr : i_redirect_adr;
    w_issue     = (r_state == S_RUN) && ((r_level + LVL_W'(r_inflight)) < DEPTH_L) &&
                  !i_hold && !i_redirect && !i_start;
    w_push      = r_inflight && (r_state == S_RUN) && !w_redir;
    w_pop       = i_byte_pop && w_valid && (r_state == S_RUN) && !w_redir;
    w_state_nxt = r_state;
    // A read returning during the redirect cycle would land in the new stream, so burn one cycle.
    if (w_redir) w_state_nxt = r_inflight ? S_FLUSH : S_RUN;
    else if (r_state == S_FLUSH) w_state_nxt = S_RUN;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_fetch_ptr <= '0;
      r_head_pc   <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_inflight  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_redir) begin
        r_fetch_ptr <= w_target;
        r_head_pc   <= w_target;
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_level     <= '0;
      end else begin
        if (w_issue) r_fetch_ptr <= r_fetch_ptr + ADR_W'(1);
        if (w_pop) begin
          r_head_pc <= r_head_pc + ADR_W'(1);
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push) begin
          r_mem[r_wr_ptr] <= i_iram_q;
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
        if (w_push && !w_pop) r_level <= r_level + LVL_W'(1);
        else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_bytes, r_stat_starve;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_start) begin
      r_stat_bytes  <= '0;
      r_stat_starve <= '0;
    end else begin
      if (w_pop && (r_stat_bytes != 32'hFFFF_FFFF)) r_stat_bytes <= r_stat_bytes + 32'd1;
      if ((r_state == S_RUN) && w_waiting && !i_hold && (r_stat_starve != 32'hFFFF_FFFF))
        r_stat_starve <= r_stat_starve + 32'd1;
    end
  end

  assign o_stat_bytes  = r_stat_bytes;
  assign o_stat_starve = r_stat_starve;
`endif

  assign o_iram_rd    = w_issue;
  assign o_iram_adr   = r_fetch_ptr;
  assign o_byte_valid = w_valid;
  assign o_byte_data  = w_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign o_waiting    = w_waiting;
  assign o_head_pc    = r_head_pc;
  assign o_level      = r_level;
  assign o_state      = r_state;

endmodule

// File: tb/tb_bytecode_fetch_ctrl.sv
// Self-checking bench for bytecode_fetch_ctrl: directed scenarios then random traffic against a queue model.
module tb_bytecode_fetch_ctrl;
  localparam int ADR_W = 16;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1, start = 1'b0, redirect = 1'b0, hold = 1'b0, byte_pop = 1'b0;
  logic [ADR_W-1:0] start_adr = '0, redirect_adr = '0;
  logic [7:0]       iram_q = 8'h00;
  logic             iram_rd, byte_valid, waiting;
  logic [ADR_W-1:0] iram_adr, head_pc;
  logic [7:0]       byte_data;
  logic [LVL_W-1:0] level;
  logic [1:0]       state;
`ifdef FETCH_STATS_EN
  logic [31:0]      stat_bytes, stat_starve;
`endif

  bytecode_fetch_ctrl #(.ADR_W(ADR_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_start_adr(start_adr),
    .i_redirect(redirect), .i_redirect_adr(redirect_adr), .i_hold(hold),
    .o_iram_rd(iram_rd), .o_iram_adr(iram_adr), .i_iram_q(iram_q),
    .o_byte_data(byte_data), .o_byte_valid(byte_valid), .i_byte_pop(byte_pop),
    .o_waiting(waiting), .o_head_pc(head_pc), .o_level(level),
`ifdef FETCH_STATS_EN
    .o_stat_bytes(stat_bytes), .o_stat_starve(stat_starve),
`endif
    .o_state(state)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_rd  = 0;
  bit chk_en = 1'b0;

  // reference model: mode 0 idle, 1 run, 2 flush; queue of expected bytes
  int               m_mode = 0;
  logic [ADR_W-1:0] m_fetch = '0, m_head = '0, m_ret_adr = '0;
  bit               m_ret = 1'b0;
  logic [7:0]       exp_q[$];
  longint           m_bytes = 0, m_starve = 0;

  function automatic logic [7:0] iram_byte(input logic [ADR_W-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle with the given inputs, check, then advance the model
  task automatic cycle(input bit rst, input bit st, input logic [ADR_W-1:0] sa,
                       input bit rdr, input logic [ADR_W-1:0] ra, input bit hl, input bit pp);
    bit e_rd, e_valid, e_wait, rd_s;
    logic [ADR_W-1:0] adr_s;
    @(negedge clk);
    reset = rst; start = st; start_adr = sa; redirect = rdr; redirect_adr = ra;
    hold = hl; byte_pop = pp;
    #1;
    e_valid = (exp_q.size() > 0);
    e_rd    = (m_mode == 1) && ((exp_q.size() + int'(m_ret)) < DEPTH) && !hl && !rdr && !st;
    e_wait  = (m_mode == 0) || !e_valid;
    if (chk_en) begin
      chk("iram_rd", 32'(iram_rd), 32'(e_rd));
      chk("iram_adr", 32'(iram_adr), 32'(m_fetch));
      chk("byte_valid", 32'(byte_valid), 32'(e_valid));
      chk("byte_data", 32'(byte_data), e_valid ? 32'(exp_q[0]) : 32'h0);
      chk("waiting", 32'(waiting), 32'(e_wait));
      chk("head_pc", 32'(head_pc), 32'(m_head));
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("state_idle", 32'(state == 2'd0), 32'(m_mode == 0));
`ifdef FETCH_STATS_EN
      chk("stat_bytes", stat_bytes, m_bytes[31:0]);
      chk("stat_starve", stat_starve, m_starve[31:0]);
`endif
    end
    rd_s  = iram_rd;
    adr_s = iram_adr;
    if (iram_rd) n_rd++;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_fetch = '0; m_head = '0; m_ret = 1'b0;
      exp_q.delete(); m_bytes = 0; m_starve = 0;
    end else begin
      if ((m_mode == 1) && e_wait && !hl && (m_starve < 64'hFFFF_FFFF)) m_starve++;
      if (st || (rdr && m_mode != 0)) begin
        exp_q.delete();
        m_fetch = st ? sa : ra;
        m_head  = m_fetch;
        m_mode  = m_ret ? 2 : 1;
      end else if (m_mode == 2) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (pp && e_valid) begin
          void'(exp_q.pop_front());
          m_head++;
          if (m_bytes < 64'hFFFF_FFFF) m_bytes++;
        end
        if (m_ret) exp_q.push_back(iram_byte(m_ret_adr));
      end
      if (st) begin m_bytes = 0; m_starve = 0; end
      m_ret_adr = m_fetch;
      if (e_rd) m_fetch++;
      m_ret = e_rd;
    end
    #1;
    iram_q = rd_s ? iram_byte(adr_s) : 8'($urandom);
  endtask

  task automatic run(input int n, input bit hl, input bit pp);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, hl, pp);
  endtask

  task automatic do_start(input logic [ADR_W-1:0] a, input bit pp);
    cycle(1'b0, 1'b1, a, 1'b0, '0, 1'b0, pp);
  endtask

  initial begin
    // reset, streaming from 0x0010 with pop held high
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    do_start(16'h0010, 1'b1);
    run(8, 1'b0, 1'b1);

    // no consumer: exactly DEPTH reads, then one pop frees one slot
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    do_start(16'h0000, 1'b0);
    n_rd = 0;
    run(10, 1'b0, 1'b0);
    chk("rd_count", 32'(n_rd), 32'(DEPTH));
    chk("level_full", 32'(level), 32'(DEPTH));
    run(1, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0);

    // redirect with queue 0x20..0x22 and 0x23 returning
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    do_start(16'h0020, 1'b0);
    run(4, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 16'h0100, 1'b0, 1'b1);
    run(6, 1'b0, 1'b1);

    // start while running acts as redirect; address wrap at 0xFFFF
    do_start(16'hFFFE, 1'b1);
    run(8, 1'b0, 1'b1);

    // hold with one read in flight
    do_start(16'h0040, 1'b1);
    run(1, 1'b0, 1'b1);
    run(5, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);

    // reset mid-operation with data queued and a read issued
    do_start(16'h0080, 1'b1);
    run(3, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b1);
    chk("post_reset_level", 32'(level), 32'h0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [ADR_W-1:0] sa, ra;
      sa = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, sa,
            $urandom_range(0, 14) == 0, ra, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
